// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - 4-digit common-anode 7-seg scan multiplexer with per-frame snapshot.
// Optional build macro: LEADING_ZERO_BLANK_EN (darkens leading zero digits).
module seg7_scan_mux #(
  parameter int SCAN_DIV     = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg7,
  output logic        dp,
  output logic [1:0]  digit_idx,
  output logic        frame_tick
);

  localparam int CW = ($clog2(SCAN_DIV) > 0) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW:0]   BLANK_W = (CW + 1)'(BLANK_CYCLES);

  generate
    if (SCAN_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_params
      $error("seg7_scan_mux: need SCAN_DIV >= 2 and 0 <= BLANK_CYCLES < SCAN_DIV");
    end
  endgenerate

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic [3:0]    dp_snap_q, dp_snap_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick_q, tick_d;
  logic [3:0]    cur_nib;
  logic          lit;

  function automatic logic [6:0] hexdec(input logic [3:0] h);
    case (h)
      4'h0: hexdec = 7'b0000001;
      4'h1: hexdec = 7'b1001111;
      4'h2: hexdec = 7'b0010010;
      4'h3: hexdec = 7'b0000110;
      4'h4: hexdec = 7'b1001100;
      4'h5: hexdec = 7'b0100100;
      4'h6: hexdec = 7'b0100000;
      4'h7: hexdec = 7'b0001111;
      4'h8: hexdec = 7'b0000000;
      4'h9: hexdec = 7'b0000100;
      4'hA: hexdec = 7'b0001000;
      4'hB: hexdec = 7'b1100000;
      4'hC: hexdec = 7'b0110001;
      4'hD: hexdec = 7'b1000010;
      4'hE: hexdec = 7'b0110000;
      default: hexdec = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    dp_snap_d = dp_snap_q;
    tick_d    = 1'b0;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
      // Snapshot only at the frame boundary so a frame never mixes two input words.
      if (idx_q == 2'd3) begin
        snap_d    = value;
        dp_snap_d = dp_in;
        tick_d    = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    cur_nib = snap_q[{idx_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    // Lit if this digit or any higher one is nonzero or carries a decimal point.
    lit = (idx_q == 2'd0) || (|(snap_q >> {idx_q, 2'b00})) || (|(dp_snap_q >> idx_q));
`else
    lit = 1'b1;
`endif

    an_d  = ({1'b0, cnt_q} < BLANK_W) ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = lit ? hexdec(cur_nib) : 7'b1111111;
    dp_d  = lit ? ~dp_snap_q[idx_q] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      snap_q    <= 16'h0;
      dp_snap_q <= 4'h0;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
      dp_q      <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      dp_snap_q <= dp_snap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      tick_q    <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg7       = seg_q;
  assign dp         = dp_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

endmodule
